// File: rtl/memory_game_ctrl_if.sv
// Signal bundle between the game sequencer and its environment: start/deck
// and button pulses in, per-card display vectors and score state out.
interface memory_game_ctrl_if #(
    parameter int N_CARDS = 8,
    parameter int SUIT_W  = 2
);
    localparam int CW = $clog2(N_CARDS);
    localparam int SW = $clog2(N_CARDS / 2 + 1);

    logic                        start;
    logic [N_CARDS*SUIT_W-1:0]   deck;
    logic                        btn_left;
    logic                        btn_right;
    logic                        btn_sel;
    logic [N_CARDS-1:0]          face_up;
    logic [N_CARDS-1:0]          highlight;
    logic [N_CARDS-1:0]          matched;
    logic [CW-1:0]               cursor;
    logic                        player;
    logic [SW-1:0]               score0;
    logic [SW-1:0]               score1;
    logic                        game_over;
    logic                        busy_show;

    // Environment side: drives start, deck and buttons.
    modport master (
        output start, deck, btn_left, btn_right, btn_sel,
        input  face_up, highlight, matched, cursor, player,
               score0, score1, game_over, busy_show
    );

    // Sequencer side.
    modport slave (
        input  start, deck, btn_left, btn_right, btn_sel,
        output face_up, highlight, matched, cursor, player,
               score0, score1, game_over, busy_show
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the two-player card-matching game. Tracks the cursor,
// the two picks of a turn, a reveal timer and both scores; every output is
// a register so the card renderers see glitch-free face_up/highlight.
module memory_game_ctrl #(
    parameter int N_CARDS    = 8,
    parameter int SUIT_W     = 2,
    parameter int SHOW_TICKS = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    memory_game_ctrl_if.slave bus
);
    localparam int CW = $clog2(N_CARDS);
    localparam int SW = $clog2(N_CARDS / 2 + 1);
    // One bit minimum so SHOW_TICKS == 1 still has a legal timer.
    localparam int TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(N_CARDS - 1);
    localparam logic [TW-1:0] T_END = TW'(SHOW_TICKS - 1);

    typedef enum logic [2:0] {IDLE, PICK1, PICK2, SHOW, DONE} state_t;

    state_t                          r_state,    w_state_nx;
    logic [N_CARDS-1:0][SUIT_W-1:0]  r_deck,     w_deck_nx;
    logic [N_CARDS-1:0]              r_face,     w_face_nx;
    logic [N_CARDS-1:0]              r_matched,  w_matched_nx;
    logic [N_CARDS-1:0]              r_hl,       w_hl_nx;
    logic [CW-1:0]                   r_cursor,   w_cursor_nx;
    logic [CW-1:0]                   r_first,    w_first_nx;
    logic [CW-1:0]                   r_second,   w_second_nx;
    logic [TW-1:0]                   r_timer,    w_timer_nx;
    logic                            r_player,   w_player_nx;
    logic [SW-1:0]                   r_score0,   w_score0_nx;
    logic [SW-1:0]                   r_score1,   w_score1_nx;
    logic                            r_over,     w_over_nx;
    logic                            r_busy,     w_busy_nx;
    logic                            w_mv_r;
    logic                            w_mv_l;
    logic                            w_sel_ok;

    // State and all output registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_deck    <= '0;
            r_face    <= '0;
            r_matched <= '0;
            r_hl      <= '0;
            r_cursor  <= '0;
            r_first   <= '0;
            r_second  <= '0;
            r_timer   <= '0;
            r_player  <= 1'b0;
            r_score0  <= '0;
            r_score1  <= '0;
            r_over    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_deck    <= w_deck_nx;
            r_face    <= w_face_nx;
            r_matched <= w_matched_nx;
            r_hl      <= w_hl_nx;
            r_cursor  <= w_cursor_nx;
            r_first   <= w_first_nx;
            r_second  <= w_second_nx;
            r_timer   <= w_timer_nx;
            r_player  <= w_player_nx;
            r_score0  <= w_score0_nx;
            r_score1  <= w_score1_nx;
            r_over    <= w_over_nx;
            r_busy    <= w_busy_nx;
        end
    end

    // Next-state: start wins over everything, then pick / move / resolve.
    always_comb begin
        w_state_nx   = r_state;
        w_deck_nx    = r_deck;
        w_face_nx    = r_face;
        w_matched_nx = r_matched;
        w_cursor_nx  = r_cursor;
        w_first_nx   = r_first;
        w_second_nx  = r_second;
        w_timer_nx   = r_timer;
        w_player_nx  = r_player;
        w_score0_nx  = r_score0;
        w_score1_nx  = r_score1;
        w_hl_nx      = '0;
        // Opposite buttons together cancel out.
        w_mv_r       = bus.btn_right & ~bus.btn_left;
        w_mv_l       = bus.btn_left  & ~bus.btn_right;
        // Second pick may not repeat the first; matched cards are never pickable.
        w_sel_ok     = ~r_matched[r_cursor] &
                       ((r_state == PICK1) | (r_cursor != r_first));

        if (bus.start) begin
            w_state_nx   = PICK1;
            w_deck_nx    = bus.deck;
            w_face_nx    = '0;
            w_matched_nx = '0;
            w_cursor_nx  = '0;
            w_first_nx   = '0;
            w_second_nx  = '0;
            w_timer_nx   = '0;
            w_player_nx  = 1'b0;
            w_score0_nx  = '0;
            w_score1_nx  = '0;
        end else begin
            case (r_state)
                PICK1, PICK2: begin
                    // A select uses the pre-move cursor and swallows any move.
                    if (bus.btn_sel) begin
                        if (w_sel_ok) begin
                            w_face_nx[r_cursor] = 1'b1;
                            if (r_state == PICK1) begin
                                w_first_nx = r_cursor;
                                w_state_nx = PICK2;
                            end else begin
                                w_second_nx = r_cursor;
                                w_timer_nx  = '0;
                                w_state_nx  = SHOW;
                            end
                        end
                    end else if (w_mv_r) begin
                        w_cursor_nx = (r_cursor == LAST) ? '0 : r_cursor + 1'b1;
                    end else if (w_mv_l) begin
                        w_cursor_nx = (r_cursor == '0) ? LAST : r_cursor - 1'b1;
                    end
                end
                SHOW: begin
                    w_timer_nx = r_timer + 1'b1;
                    if (r_timer == T_END) begin
                        w_timer_nx = '0;
                        if (r_deck[r_first] == r_deck[r_second]) begin
                            w_matched_nx[r_first]  = 1'b1;
                            w_matched_nx[r_second] = 1'b1;
                            if (r_player) w_score1_nx = r_score1 + 1'b1;
                            else          w_score0_nx = r_score0 + 1'b1;
                        end else begin
                            w_face_nx[r_first]  = 1'b0;
                            w_face_nx[r_second] = 1'b0;
                            w_player_nx         = ~r_player;
                        end
                        w_state_nx = (&w_matched_nx) ? DONE : PICK1;
                    end
                end
                default: ;
            endcase
        end

        // Derived outputs follow the next state so they register in step.
        if (w_state_nx == PICK1 || w_state_nx == PICK2 || w_state_nx == SHOW)
            w_hl_nx[w_cursor_nx] = 1'b1;
        w_over_nx = (w_state_nx == DONE);
        w_busy_nx = (w_state_nx == SHOW);
    end

    assign bus.face_up   = r_face;
    assign bus.highlight = r_hl;
    assign bus.matched   = r_matched;
    assign bus.cursor    = r_cursor;
    assign bus.player    = r_player;
    assign bus.score0    = r_score0;
    assign bus.score1    = r_score1;
    assign bus.game_over = r_over;
    assign bus.busy_show = r_busy;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: directed game scenarios followed by random
// button traffic, all compared each cycle against a turn-level game model.
module tb_memory_game_ctrl;
    localparam int N  = 8;
    localparam int ST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_game_ctrl_if #(.N_CARDS(N), .SUIT_W(2)) bus();

    memory_game_ctrl #(.N_CARDS(N), .SUIT_W(2), .SHOW_TICKS(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [2*N-1:0] deck_v;

    // Game model: a game in progress, picks of the current turn as a queue,
    // remaining reveal cycles, per-player score array.
    bit         m_play, m_over;
    int         m_cur, m_plr, m_show;
    int         m_sc[2];
    bit [N-1:0] m_up, m_mt;
    int         m_picks[$];
    int         m_suit[N];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_play = 0; m_over = 0; m_cur = 0; m_plr = 0; m_show = 0;
        m_sc[0] = 0; m_sc[1] = 0; m_up = '0; m_mt = '0;
        m_picks.delete();
    endtask

    task automatic m_step(bit st, bit l, bit r, bit s);
        int a, b;
        if (st) begin
            m_reset();
            m_play = 1;
            for (int i = 0; i < N; i++) m_suit[i] = int'(deck_v[i*2 +: 2]);
            return;
        end
        if (!m_play) return;
        if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                a = m_picks[0]; b = m_picks[1];
                if (m_suit[a] == m_suit[b]) begin
                    m_mt[a] = 1; m_mt[b] = 1; m_sc[m_plr]++;
                end else begin
                    m_up[a] = 0; m_up[b] = 0; m_plr = 1 - m_plr;
                end
                m_picks.delete();
                if (&m_mt) begin m_play = 0; m_over = 1; end
            end
            return;
        end
        if (s) begin
            if (!m_mt[m_cur] && !(m_picks.size() == 1 && m_picks[0] == m_cur)) begin
                m_up[m_cur] = 1;
                m_picks.push_back(m_cur);
                if (m_picks.size() == 2) m_show = ST;
            end
            return;
        end
        if (l != r) m_cur = (m_cur + (r ? 1 : N - 1)) % N;
    endtask

    task automatic check_all();
        chk("face_up",   32'(bus.face_up),   32'(m_up));
        chk("matched",   32'(bus.matched),   32'(m_mt));
        chk("highlight", 32'(bus.highlight), m_play ? (32'd1 << m_cur) : 32'd0);
        chk("cursor",    32'(bus.cursor),    m_play ? 32'(m_cur) : 32'(bus.cursor === 'x ? 0 : m_cur));
        chk("player",    32'(bus.player),    32'(m_plr));
        chk("score0",    32'(bus.score0),    32'(m_sc[0]));
        chk("score1",    32'(bus.score1),    32'(m_sc[1]));
        chk("game_over", 32'(bus.game_over), 32'(m_over));
        chk("busy_show", 32'(bus.busy_show), 32'(m_show > 0));
    endtask

    task automatic cyc(bit st, bit l, bit r, bit s);
        @(negedge clk);
        bus.start = st; bus.btn_left = l; bus.btn_right = r; bus.btn_sel = s;
        bus.deck  = deck_v;
        m_step(st, l, r, s);
        @(posedge clk);
        #1;
        bus.start = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_sel = 0;
        check_all();
    endtask

    task automatic goto(int t);
        for (int k = 0; k < N && m_cur != t; k++) cyc(0, 0, 1, 0);
    endtask

    task automatic pick_pair(int a, int b);
        goto(a); cyc(0, 0, 0, 1);
        goto(b); cyc(0, 0, 0, 1);
        repeat (ST) cyc(0, 0, 0, 0);
    endtask

    task automatic fixed_deck();
        for (int i = 0; i < N; i++) deck_v[i*2 +: 2] = 2'(i % 4);
    endtask

    initial begin
        bus.start = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_sel = 0;
        fixed_deck();
        bus.deck = deck_v;
        m_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Start, some play, then reset mid-cycle must clear at once.
        cyc(1, 0, 0, 0);
        chk("hl_after_start", 32'(bus.highlight), 32'h01);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        m_reset();
        check_all();
        chk("cursor_rst", 32'(bus.cursor), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Wrap and simultaneous buttons.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("wrap_left", 32'(bus.cursor), 32'd7);
        cyc(0, 0, 1, 0);
        chk("wrap_right", 32'(bus.cursor), 32'd0);
        cyc(0, 1, 1, 0);
        chk("both_btn", 32'(bus.cursor), 32'd0);

        // Match 0/4.
        cyc(0, 0, 0, 1);
        goto(4); cyc(0, 0, 0, 1);
        chk("reveal_pair", 32'(bus.face_up), 32'h11);
        repeat (ST) cyc(0, 0, 0, 0);
        chk("matched_04", 32'(bus.matched), 32'h11);
        chk("score0_1", 32'(bus.score0), 32'd1);

        // Mismatch 1/2.
        pick_pair(1, 2);
        chk("mismatch_face", 32'(bus.face_up), 32'h11);
        chk("mismatch_plr", 32'(bus.player), 32'd1);

        // Illegal picks and buttons while showing.
        goto(0); cyc(0, 0, 0, 1);
        goto(1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        goto(3); cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
        chk("after_show_cur", 32'(bus.cursor), 32'd3);

        // Finish the game.
        pick_pair(1, 5); pick_pair(2, 6); pick_pair(3, 7);
        chk("game_over", 32'(bus.game_over), 32'd1);
        chk("face_all", 32'(bus.face_up), 32'hFF);
        chk("score_sum", 32'(bus.score0) + 32'(bus.score1), 32'd4);

        // Restart during a reveal discards it.
        cyc(1, 0, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("restart_face", 32'(bus.face_up), 32'h00);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            bit st;
            st = ($urandom_range(0, 249) == 0);
            if (st) begin
                if ($urandom_range(0, 1) == 0) fixed_deck();
                else deck_v = 16'($urandom);
            end
            cyc(st, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
